// File: rtl/fnd_pkg.sv
// Shared constants, segment table and conversion state type for the FND display controller.
package fnd_pkg;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for digits 0..9, dp off.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    if (nib <= 4'd9) return SEG_DIGIT[nib];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: clamps the input, shifts 14 bits through a 16-bit BCD accumulator.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int MAX_VALUE = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] din,
  output logic [BCD_W-1:0] bcd,
  output logic             done,
  output logic             busy
);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VALUE);

  conv_state_t      state;
  conv_state_t      state_next;
  logic             pending;
  logic             start;
  logic [BIN_W-1:0] last_raw;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [3:0]       count;

  // The raw input is remembered so an out-of-range value does not retrigger forever.
  assign start = pending || (din != last_raw);

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == 4'd13) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b1;
      last_raw <= '0;
      bin_sr   <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_raw <= din;
            bin_sr   <= (din > MAX_BIN) ? MAX_BIN : din;
            acc      <= '0;
            count    <= '0;
          end
        end
        SHIFT: begin
          acc    <= {acc_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
          bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
          count  <= count + 4'd1;
        end
        DONE:    pending <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bcd  = acc;
  assign done = (state == DONE);
  assign busy = (state == SHIFT);

endmodule

// File: rtl/fnd_display_controller.sv
// 4-digit common-anode FND driver: BCD conversion, digit scan, leading-zero blanking, animation override.
module fnd_display_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int MAX_VALUE = 9999,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] display_data,
  input  logic             coffee_making_flag,
  input  logic [7:0]       animation_seg,
  input  logic [3:0]       animation_an,
  output logic [7:0]       seg,
  output logic [3:0]       an,
  output logic             conv_busy
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0] prescale;
  logic [1:0]       slot;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;
  logic [BCD_W-1:0] disp_bcd;
  logic [1:0]       msd;
  logic [3:0]       digit;
  logic [7:0]       seg_next;
  logic [3:0]       an_next;

  bin2bcd_seq #(.MAX_VALUE(MAX_VALUE)) u_conv (
    .clk   (clk),
    .reset (reset),
    .din   (display_data),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  // Displayed digits only change on a completed conversion, never mid-shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          disp_bcd <= '0;
    else if (conv_done) disp_bcd <= conv_bcd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      slot     <= '0;
    end else if (prescale == PRE_W'(SCAN_DIV - 1)) begin
      prescale <= '0;
      slot     <= slot + 2'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0) msd = 2'(i);
    end
    digit    = disp_bcd[4*slot +: 4];
    seg_next = seg_decode(digit) | 8'h80;
    an_next  = ~(4'b0001 << slot);
    if (BLANK_LZ && (slot > msd)) begin
      seg_next = SEG_BLANK;
      an_next  = AN_OFF;
    end
    if (coffee_making_flag) begin
      seg_next = animation_seg;
      an_next  = animation_an;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_fnd_display_controller.sv
// Directed and random checks of the FND controller against an arithmetic display model.
module tb_fnd_display_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] display_data;
  logic        coffee_making_flag;
  logic [7:0]  animation_seg;
  logic [3:0]  animation_an;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        conv_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_cnt;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_display_controller #(.SCAN_DIV(4), .MAX_VALUE(9999), .BLANK_LZ(1'b1)) dut (
    .clk                (clk),
    .reset              (reset),
    .display_data       (display_data),
    .coffee_making_flag (coffee_making_flag),
    .animation_seg      (animation_seg),
    .animation_an       (animation_an),
    .seg                (seg),
    .an                 (an),
    .conv_busy          (conv_busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the slot an output reflects follows from this.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int val;
    val = clamp(v);
    return 16'((val / 1000) * 4096 + ((val / 100) % 10) * 256 + ((val / 10) % 10) * 16 + val % 10);
  endfunction

  function automatic void model_out(input int k, input int v, input bit flag,
                                    input logic [7:0] aseg, input logic [3:0] aan,
                                    output logic [7:0] es, output logic [3:0] ea);
    int val, s, msd, p;
    int d[4];
    if (flag) begin
      es = aseg;
      ea = aan;
      return;
    end
    val = clamp(v);
    p = 1;
    msd = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = (val / p) % 10;
      if (d[i] != 0) msd = i;
      p = p * 10;
    end
    s = ((k - 1) / 4) % 4;
    es = 8'hFF;
    ea = 4'hF;
    if (s <= msd) begin
      es = seg_tab[d[s]];
      ea[s] = 1'b0;
    end
  endfunction

  task automatic scan_check(input string tag, input int v);
    logic [7:0] es;
    logic [3:0] ea;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      model_out(edge_cnt, v, coffee_making_flag, animation_seg, animation_an, es, ea);
      chk({tag, " seg"}, 32'(seg), 32'(es));
      chk({tag, " an"}, 32'(an), 32'(ea));
    end
  endtask

  task automatic settle_check(input string tag, input int v);
    repeat (40) @(negedge clk);
    chk({tag, " busy idle"}, 32'(conv_busy), 32'd0);
    chk({tag, " bcd"}, 32'(dut.disp_bcd), 32'(to_bcd(v)));
    scan_check(tag, v);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (conv_busy !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy rise"}, 32'(conv_busy), 32'd1);
  endtask

  initial begin
    int busy_cycles, elapsed, v;

    reset = 1'b1;
    display_data = 14'd0;
    coffee_making_flag = 1'b0;
    animation_seg = 8'hFF;
    animation_an = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset seg", 32'(seg), 32'hFF);
    chk("reset an", 32'(an), 32'hF);
    chk("reset busy", 32'(conv_busy), 32'd0);

    // Power-up conversion of zero
    reset = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk("busy first cycle", 32'(conv_busy), 32'd1);
      if (conv_busy === 1'b1) busy_cycles++;
    end
    chk("busy length", 32'(busy_cycles), 32'd14);
    chk("zero bcd", 32'(dut.disp_bcd), 32'h0000);
    scan_check("zero", 0);

    display_data = 14'd300;
    settle_check("v300", 300);
    display_data = 14'd9999;
    settle_check("v9999", 9999);
    display_data = 14'd12000;
    settle_check("v12000", 12000);

    // Change during conversion: 100 then 500 on the 5th shift cycle
    display_data = 14'd0;
    settle_check("v0", 0);
    display_data = 14'd100;
    elapsed = 0;
    wait_busy("chg");
    elapsed = 1;
    repeat (4) begin
      @(negedge clk);
      elapsed++;
    end
    display_data = 14'd500;
    while (conv_busy === 1'b1 && elapsed < 40) begin
      @(negedge clk);
      elapsed++;
    end
    @(negedge clk);
    elapsed++;
    chk("chg first bcd", 32'(dut.disp_bcd), 32'h0100);
    while (dut.disp_bcd !== 16'h0500 && elapsed < 60) begin
      @(negedge clk);
      elapsed++;
    end
    chk("chg second bcd", 32'(dut.disp_bcd), 32'h0500);
    chk("chg within 34", 32'(elapsed <= 34), 32'd1);
    settle_check("v500 hold", 500);

    // Animation override, held across slot wraps, then released
    coffee_making_flag = 1'b1;
    animation_seg = 8'hFE;
    animation_an = 4'h0;
    scan_check("override", 500);
    coffee_making_flag = 1'b0;
    scan_check("override off", 500);

    // Reset on the 7th shift cycle
    display_data = 14'd4321;
    wait_busy("rst");
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset seg", 32'(seg), 32'hFF);
    chk("midreset an", 32'(an), 32'hF);
    chk("midreset busy", 32'(conv_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    settle_check("after reset", 4321);

    // Random values with occasional random animation frames
    for (int r = 0; r < 8; r++) begin
      v = int'($urandom_range(0, 16383));
      display_data = 14'(v);
      settle_check("random", v);
      if (($urandom & 1) == 1) begin
        coffee_making_flag = 1'b1;
        animation_seg = 8'($urandom);
        animation_an = 4'($urandom);
        scan_check("random override", v);
        coffee_making_flag = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
